// File: rtl/multiplier_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier, radix-2 shift-and-add,
// one multiplier bit per clock behind a start/busy/finish handshake.
module multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 finish_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     count;
    logic                 last_iter;

    // Next-state logic; the partial sum is formed here so the final
    // iteration can be written straight into result_o.
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        last_iter  = 1'b0;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (count == LAST_ITER) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            result_o <= '0;
            finish_o <= 1'b0;
        end else begin
            finish_o <= last_iter;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mcand  <= {{WIDTH{1'b0}}, a_i};
                        mplier <= b_i;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    // result_o only moves on completion, so the old product
                    // stays visible throughout a following operation.
                    if (last_iter) begin
                        result_o <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// Bench for multiplier_seq: a timing/arithmetic model checked every cycle,
// plus directed operations with hand-computed products and latencies.
module tb_multiplier_seq;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rstN = 1'b1;
    logic            startI = 1'b0;
    logic [W-1:0]    aI = '0;
    logic [W-1:0]    bI = '0;
    logic            busyO;
    logic            finishO;
    logic [2*W-1:0]  resultO;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int busyRun = 0;
    int finishCount = 0;
    bit cmpEn = 1'b0;

    int             mRemain = 0;
    logic [2*W-1:0] mPending = '0;
    logic [2*W-1:0] mResult = '0;
    logic           mFinish = 1'b0;

    multiplier_seq #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rstN),
        .start_i  (startI),
        .a_i      (aI),
        .b_i      (bI),
        .busy_o   (busyO),
        .finish_o (finishO),
        .result_o (resultO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Model: an accepted start schedules the product to appear W edges later.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mRemain = 0;
            mResult = '0;
            mFinish = 1'b0;
        end else begin
            mFinish = 1'b0;
            if (mRemain > 0) begin
                mRemain--;
                if (mRemain == 0) begin
                    mResult = mPending;
                    mFinish = 1'b1;
                end
            end else if (startI) begin
                mPending = 64'(aI) * 64'(bI);
                mRemain  = W;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        busyRun     += int'(busyO);
        finishCount += int'(finishO);
        if (cmpEn) begin
            checkOutput("busy", 64'(busyO), 64'(mRemain > 0));
            checkOutput("finish", 64'(finishO), 64'(mFinish));
            checkOutput("result", resultO, mResult);
        end
    end

    // Called at posedge+2; returns at posedge+2 with start dropped and the
    // operand inputs scrambled so any late sampling would be visible.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int hold);
        aI      = a;
        bI      = b;
        startI  = 1'b1;
        busyRun = 0;
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        if (hold > 1) begin
            repeat (hold - 1) @(posedge clk);
            #2;
        end else begin
            #1;
        end
        startI = 1'b0;
        aI     = ~a;
        bI     = b ^ 32'h5A5A_A5A5;
    endtask

    task automatic waitDone(output int lat);
        int n = 0;
        lat = -1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (finishO) begin
                lat = cyc - acceptCyc;
                break;
            end
        end
        #1;
        if (lat < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL finish timeout: got no finish in 100 cycles, want one");
        end
    endtask

    initial begin
        int lat;
        #1 rstN = 1'b0;
        cmpEn = 1'b1;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("idle busy", 64'(busyO), 64'd0);
        checkOutput("idle finish", 64'(finishO), 64'd0);
        checkOutput("idle result", resultO, 64'd0);

        $display("[TB] 3 x 5");
        applyStimulus(32'd3, 32'd5, 1);
        waitDone(lat);
        checkOutput("3x5 latency", 64'(lat), 64'd32);
        checkOutput("3x5 busy cycles", 64'(busyRun), 64'd32);
        checkOutput("3x5 product", resultO, 64'd15);
        repeat (3) @(posedge clk);
        #2;

        $display("[TB] max x max");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        waitDone(lat);
        checkOutput("max product", resultO, 64'hFFFF_FFFE_0000_0001);
        repeat (2) @(posedge clk);
        #2;

        applyStimulus(32'd0, 32'd12345, 1);
        waitDone(lat);
        checkOutput("zero product", resultO, 64'd0);
        repeat (2) @(posedge clk);
        #2;

        applyStimulus(32'd1, 32'h8000_0000, 1);
        waitDone(lat);
        checkOutput("msb product", resultO, 64'h0000_0000_8000_0000);
        repeat (2) @(posedge clk);
        #2;

        $display("[TB] start held two cycles");
        finishCount = 0;
        applyStimulus(32'h0000_FFFF, 32'h0001_0001, 2);
        waitDone(lat);
        checkOutput("held latency", 64'(lat), 64'd32);
        checkOutput("held product", resultO, 64'h0000_0000_FFFF_FFFF);
        repeat (40) @(posedge clk);
        #2;
        checkOutput("held finish pulses", 64'(finishCount), 64'd1);

        $display("[TB] back-to-back");
        applyStimulus(32'd7, 32'd9, 1);
        waitDone(lat);
        checkOutput("b2b first product", resultO, 64'd63);
        applyStimulus(32'h1234_5678, 32'h0000_0010, 1);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("b2b held result", resultO, 64'd63);
        waitDone(lat);
        checkOutput("b2b second latency", 64'(lat), 64'd32);
        checkOutput("b2b second product", resultO, 64'h0000_0001_2345_6780);
        repeat (2) @(posedge clk);
        #2;

        $display("[TB] reset mid-operation");
        applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, 1);
        repeat (9) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busyO), 64'd0);
        checkOutput("abort finish", 64'(finishO), 64'd0);
        checkOutput("abort result", resultO, 64'd0);
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        applyStimulus(32'd1000, 32'd1000, 1);
        waitDone(lat);
        checkOutput("fresh latency", 64'(lat), 64'd32);
        checkOutput("fresh product", resultO, 64'd1000000);
        repeat (4) @(posedge clk);
        #2;

        cmpEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
